// File: rtl/preproc_axil_regs_pkg.sv
// Shared constants, register map and write-beat payload for the preprocessing register bank.
package preproc_regs_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned RESP_W   = 2;
    localparam int unsigned OFFSET_W = 16;
    localparam int unsigned SEL_W    = 5;
    localparam int unsigned LANE_W   = 8;
    localparam int unsigned HOLD_STRB_W = OFFSET_W / LANE_W;

    // Word-aligned register map
    localparam logic [ADDR_W-1:0] ADDR_OFFSET     = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_SEL_SOURCE = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_CTRL       = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_STATUS     = 4'hC;

    // Reset values of the writable registers
    localparam logic [OFFSET_W-1:0] OFFSET_RST     = 16'h0000;
    localparam logic [SEL_W-1:0]    SEL_SOURCE_RST = 5'b00000;
    localparam logic                ENABLE_RST     = 1'b0;

    localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;

    // CTRL register bit positions
    localparam int unsigned CTRL_ENABLE_BIT   = 0;
    localparam int unsigned CTRL_SOFT_RST_BIT = 1;

    // Only the low 16 data bits and two byte strobes can affect any register
    typedef struct packed {
        logic [OFFSET_W-1:0]    data;
        logic [HOLD_STRB_W-1:0] strb;
    } w_beat_t;

    // Byte-lane merge of a held write beat into a 16-bit register
    function automatic logic [OFFSET_W-1:0] merge_lanes(input logic [OFFSET_W-1:0] cur,
                                                        input w_beat_t beat);
        logic [OFFSET_W-1:0] res;
        res = cur;
        for (int b = 0; b < int'(HOLD_STRB_W); b++) begin
            if (beat.strb[b]) res[LANE_W*b +: LANE_W] = beat.data[LANE_W*b +: LANE_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/preproc_axil_regs_if.sv
// AXI4-Lite channel bundle between the initiator and the preprocessing register bank.
interface preproc_axil_regs_if;
    import preproc_regs_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [RESP_W-1:0] bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [RESP_W-1:0] rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/preproc_axil_regs.sv
// AXI4-Lite register bank driving the static controls of the preprocessing datapath.
module preproc_axil_regs
    import preproc_regs_pkg::*;
(
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    preproc_axil_regs_if.slave  s_axi,
    input  logic [DATA_W-1:0]   status_i,
    output logic [OFFSET_W-1:0] offset_o,
    output logic [SEL_W-1:0]    sel_source_o,
    output logic                enable_o,
    output logic                soft_rst_o
);

    logic              ready_en_q;
    logic              aw_held_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic              w_held_q;
    w_beat_t           w_beat_q;
    logic              bvalid_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              aw_hs_c;
    logic              w_hs_c;
    logic              b_hs_c;
    logic              ar_hs_c;
    logic              r_hs_c;
    logic              commit_c;
    logic [ADDR_W-1:0] ar_word_c;
    logic [DATA_W-1:0] rd_mux_c;

    // Byte-offset bits and upper lanes never reach a register
    logic unused_bits_c;
    assign unused_bits_c = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0],
                             s_axi.wdata[DATA_W-1:OFFSET_W], s_axi.wstrb[STRB_W-1:HOLD_STRB_W]};

    // Ready terms stay low in reset and the first cycle after it
    assign s_axi.awready = ready_en_q && !aw_held_q && !bvalid_q;
    assign s_axi.wready  = ready_en_q && !w_held_q && !bvalid_q;
    assign s_axi.arready = ready_en_q && !rvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = RESP_OKAY;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = RESP_OKAY;

    assign aw_hs_c   = s_axi.awvalid && s_axi.awready;
    assign w_hs_c    = s_axi.wvalid && s_axi.wready;
    assign b_hs_c    = bvalid_q && s_axi.bready;
    assign ar_hs_c   = s_axi.arvalid && s_axi.arready;
    assign r_hs_c    = rvalid_q && s_axi.rready;
    assign commit_c  = aw_held_q && w_held_q;
    assign ar_word_c = {s_axi.araddr[ADDR_W-1:2], 2'b00};

    // Releases the handshake readies one cycle after reset deasserts
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) ready_en_q <= 1'b0;
        else                ready_en_q <= 1'b1;
    end

    // Write channel: independent AW/W holds, commit once both present, single outstanding B
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_beat_q  <= '0;
            bvalid_q  <= 1'b0;
        end else begin
            if (aw_hs_c) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= {s_axi.awaddr[ADDR_W-1:2], 2'b00};
            end
            if (w_hs_c) begin
                w_held_q      <= 1'b1;
                w_beat_q.data <= s_axi.wdata[OFFSET_W-1:0];
                w_beat_q.strb <= s_axi.wstrb[HOLD_STRB_W-1:0];
            end
            if (commit_c) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
            end else if (b_hs_c) begin
                bvalid_q  <= 1'b0;
            end
        end
    end

    // Register file update on commit; soft reset is a single-cycle strobe
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            offset_o     <= OFFSET_RST;
            sel_source_o <= SEL_SOURCE_RST;
            enable_o     <= ENABLE_RST;
            soft_rst_o   <= 1'b0;
        end else begin
            soft_rst_o <= 1'b0;
            if (commit_c) begin
                case (aw_addr_q)
                    ADDR_OFFSET: begin
                        offset_o <= merge_lanes(offset_o, w_beat_q);
                    end
                    ADDR_SEL_SOURCE: begin
                        if (w_beat_q.strb[0]) sel_source_o <= w_beat_q.data[SEL_W-1:0];
                    end
                    ADDR_CTRL: begin
                        if (w_beat_q.strb[0]) begin
                            enable_o   <= w_beat_q.data[CTRL_ENABLE_BIT];
                            soft_rst_o <= w_beat_q.data[CTRL_SOFT_RST_BIT];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Read mux over current register values; unused bits read as zero
    always_comb begin
        rd_mux_c = '0;
        case (ar_word_c)
            ADDR_OFFSET:     rd_mux_c[OFFSET_W-1:0]   = offset_o;
            ADDR_SEL_SOURCE: rd_mux_c[SEL_W-1:0]      = sel_source_o;
            ADDR_CTRL:       rd_mux_c[CTRL_ENABLE_BIT] = enable_o;
            ADDR_STATUS:     rd_mux_c                 = status_i;
            default:         rd_mux_c                 = '0;
        endcase
    end

    // Read channel: capture on AR handshake, hold data until R handshake
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (ar_hs_c) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux_c;
            end else if (r_hs_c) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_preproc_axil_regs.sv
// Directed plus randomized bench for the preprocessing AXI4-Lite register bank.
module tb_preproc_axil_regs;
    import preproc_regs_pkg::*;

    localparam int TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] status;
    logic [15:0] offset;
    logic [4:0]  sel;
    logic        en;
    logic        srst;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference register contents
    logic [15:0] m_offset;
    logic [4:0]  m_sel;
    logic        m_en;

    preproc_axil_regs_if bus ();

    preproc_axil_regs dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi         (bus),
        .status_i      (status),
        .offset_o      (offset),
        .sel_source_o  (sel),
        .enable_o      (en),
        .soft_rst_o    (srst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_offset = 16'h0000;
        m_sel    = 5'h00;
        m_en     = 1'b0;
    endtask

    // Register map semantics: byte lanes for OFFSET, lane 0 for SEL/CTRL, STATUS read-only
    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic pulse);
        pulse = 1'b0;
        case (a[3:2])
            2'd0: begin
                if (s[0]) m_offset[7:0]  = d[7:0];
                if (s[1]) m_offset[15:8] = d[15:8];
            end
            2'd1: if (s[0]) m_sel = d[4:0];
            2'd2: if (s[0]) begin
                m_en  = d[0];
                pulse = d[1];
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {16'h0000, m_offset};
            2'd1:    return {27'h0, m_sel};
            2'd2:    return {31'h0, m_en};
            default: return status;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_offset"}, 32'(offset), 32'(m_offset));
        check({tag, "_sel"},    32'(sel),    32'(m_sel));
        check({tag, "_enable"}, 32'(en),     32'(m_en));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 32'(bus.awready), 32'h0);
        check({tag, "_wready"},  32'(bus.wready),  32'h0);
        check({tag, "_arready"}, 32'(bus.arready), 32'h0);
        check({tag, "_bvalid"},  32'(bus.bvalid),  32'h0);
        check({tag, "_rvalid"},  32'(bus.rvalid),  32'h0);
        check({tag, "_rdata"},   bus.rdata,        32'h0);
        check({tag, "_offset"},  32'(offset),      32'h0);
        check({tag, "_sel"},     32'(sel),         32'h0);
        check({tag, "_enable"},  32'(en),          32'h0);
        check({tag, "_softrst"}, 32'(srst),        32'h0);
    endtask

    // Full write transaction; during a stalled B a competing write is offered and must be refused
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit   aw_done, w_done, aw_go, w_go;
        int   cyc;
        logic pulse;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        while (!(aw_done && w_done) && cyc < TIMEOUT) begin
            bus.awaddr  = a;
            bus.wdata   = d;
            bus.wstrb   = s;
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            aw_go = bus.awvalid && bus.awready;
            w_go  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (aw_go) aw_done = 1'b1;
            if (w_go)  w_done  = 1'b1;
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("wr_handshake_done", 32'(aw_done && w_done), 32'h1);
        if (!(aw_done && w_done)) return;
        check("wr_pre_commit_bvalid", 32'(bus.bvalid), 32'h0);
        check_regs("wr_pre_commit");
        model_write(a, d, s, pulse);
        @(negedge clk);
        check("wr_bvalid", 32'(bus.bvalid), 32'h1);
        check("wr_bresp",  32'(bus.bresp),  32'h0);
        check("wr_softrst_commit", 32'(srst), 32'(pulse));
        check_regs("wr_commit");
        for (int i = 0; i < b_dly; i++) begin
            bus.awaddr  = ADDR_SEL_SOURCE;
            bus.wdata   = ~d;
            bus.wstrb   = 4'hF;
            bus.awvalid = 1'b1;
            bus.wvalid  = 1'b1;
            check("wr_stall_awready", 32'(bus.awready), 32'h0);
            check("wr_stall_wready",  32'(bus.wready),  32'h0);
            check("wr_stall_bvalid",  32'(bus.bvalid),  32'h1);
            @(negedge clk);
            if (i == 0) check("wr_softrst_after", 32'(srst), 32'h0);
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        @(negedge clk);
        bus.bready  = 1'b0;
        check("wr_bvalid_cleared", 32'(bus.bvalid), 32'h0);
        check("wr_softrst_idle",   32'(srst),       32'h0);
        check_regs("wr_done");
    endtask

    // Full read transaction; status_i is disturbed while R is stalled
    task automatic axi_read(input logic [3:0] a, input int r_dly);
        logic [31:0] exp;
        bit          go;
        int          cyc;
        go  = 1'b0;
        cyc = 0;
        exp = '0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        while (!go && cyc < TIMEOUT) begin
            exp = model_read(a);
            go  = bus.arready;
            @(negedge clk);
            cyc++;
        end
        bus.arvalid = 1'b0;
        check("rd_handshake_done", 32'(go), 32'h1);
        if (!go) return;
        check("rd_rvalid", 32'(bus.rvalid), 32'h1);
        check("rd_rresp",  32'(bus.rresp),  32'h0);
        check("rd_rdata",  bus.rdata,       exp);
        for (int i = 0; i < r_dly; i++) begin
            status = $urandom;
            @(negedge clk);
            check("rd_stall_rvalid", 32'(bus.rvalid), 32'h1);
            check("rd_stall_rdata",  bus.rdata,       exp);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check("rd_rvalid_cleared", 32'(bus.rvalid), 32'h0);
    endtask

    initial begin
        logic [3:0]  ra;
        logic [31:0] rd;
        logic [3:0]  rs;
        logic [15:0] old_offset;
        logic        p;

        rst_n       = 1'b0;
        status      = 32'h0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        model_reset();

        // Reset held for 50 clocks
        repeat (50) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        axi_read(4'h0, 0);

        // OFFSET full write, AW three clocks ahead of W, B stalled
        axi_write(4'h0, 32'h0000_1234, 4'b1111, 0, 3, 2);
        check("t2_offset", 32'(offset), 32'h1234);
        axi_read(4'h0, 0);

        // Lane-1-only write merges into the existing value
        axi_write(4'h0, 32'h0000_AB00, 4'b0010, 0, 0, 0);
        check("t3_offset", 32'(offset), 32'hAB34);

        // SEL_SOURCE, W ahead of AW, B stalled five clocks
        axi_write(4'h4, 32'h0000_001F, 4'b1111, 2, 0, 5);
        check("t4_sel", 32'(sel), 32'h1F);
        axi_read(4'h4, 0);

        // CTRL enable plus soft-reset strobe; bit 1 reads back as zero
        axi_write(4'h8, 32'h0000_0003, 4'b1111, 0, 0, 1);
        check("t5_enable", 32'(en), 32'h1);
        axi_read(4'h8, 0);

        // STATUS read with R stalled, then a write to the read-only word
        status = 32'hCAFE_0001;
        axi_read(4'hC, 4);
        axi_write(4'hC, 32'hFFFF_FFFF, 4'b1111, 0, 0, 1);

        // AR accepted on the commit edge of an OFFSET write sees the pre-write value
        old_offset  = m_offset;
        bus.awaddr  = 4'h0;
        bus.wdata   = 32'h0000_5A5A;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        check("same_edge_awready", 32'(bus.awready), 32'h1);
        check("same_edge_wready",  32'(bus.wready),  32'h1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.araddr  = 4'h0;
        bus.arvalid = 1'b1;
        check("same_edge_arready", 32'(bus.arready), 32'h1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        model_write(4'h0, 32'h0000_5A5A, 4'hF, p);
        check("same_edge_rdata_old", bus.rdata, {16'h0000, old_offset});
        check("same_edge_bvalid",    32'(bus.bvalid), 32'h1);
        check("same_edge_offset",    32'(offset), 32'(m_offset));
        bus.rready = 1'b1;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        bus.bready = 1'b0;
        check("same_edge_rvalid_cleared", 32'(bus.rvalid), 32'h0);
        check("same_edge_bvalid_cleared", 32'(bus.bvalid), 32'h0);

        // Reset asserted while a read response is pending
        status      = 32'h1234_5678;
        bus.araddr  = 4'hC;
        bus.arvalid = 1'b1;
        check("midrst_arready", 32'(bus.arready), 32'h1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("midrst_rvalid_before", 32'(bus.rvalid), 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n      = 1'b1;
        bus.rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_rbeat", 32'(bus.rvalid), 32'h0);
        end
        bus.rready = 1'b0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                rd = $urandom;
                rs = 4'($urandom);
                axi_write(ra, rd, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
            end else begin
                status = $urandom;
                axi_read(ra, int'($urandom_range(0, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
